// File: rtl/vga_fetch_pkg.sv
// Shared definitions for the VGA frame-buffer fetch scheduler:
// FSM state encoding, pixel word width and RGB field positions.
package vga_fetch_pkg;

    localparam int c_pix_bits = 24;
    localparam int c_r_lsb    = 16;
    localparam int c_g_lsb    = 8;
    localparam int c_b_lsb    = 0;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FILL = 3'd1,
        S_REQ  = 3'd2,
        S_DATA = 3'd3,
        S_DONE = 3'd4
    } fetch_state_t;

    // Extract one 8-bit colour channel from a packed {r,g,b} word.
    function automatic logic [7:0] pix_field(input logic [c_pix_bits-1:0] pix, input int lsb);
        return pix[lsb +: 8];
    endfunction

endpackage

// File: rtl/vga_fetch_fifo.sv
// Synchronous first-word-fall-through pixel FIFO. The head word is visible
// combinationally (zero when empty); flush empties it in one cycle and
// takes priority over push and pop.
module vga_fetch_fifo
    import vga_fetch_pkg::*;
#(
    parameter int c_fifo_bits = 9
) (
    input  logic                  clk_pixel,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [c_pix_bits-1:0] wdata,
    output logic [c_pix_bits-1:0] head,
    output logic [c_fifo_bits:0]  count,
    output logic [c_fifo_bits:0]  free
);

    localparam int                  c_depth_int = 2 ** c_fifo_bits;
    localparam logic [c_fifo_bits:0] c_depth     = (c_fifo_bits + 1)'(c_depth_int);
    localparam logic [c_fifo_bits:0] c_cnt_one   = (c_fifo_bits + 1)'(1);
    localparam logic [c_fifo_bits-1:0] c_ptr_one = c_fifo_bits'(1);

    logic [c_pix_bits-1:0]  mem [c_depth_int];
    logic [c_fifo_bits-1:0] wr_ptr;
    logic [c_fifo_bits-1:0] rd_ptr;
    logic                   empty;
    logic                   full;
    logic                   do_push;
    logic                   do_pop;

    assign empty   = (count == '0);
    assign full    = (count == c_depth);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign free    = c_depth - count;
    assign head    = empty ? '0 : mem[rd_ptr];

    // Storage array: written on accepted pushes only, no reset needed.
    always_ff @(posedge clk_pixel) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + c_ptr_one;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + c_ptr_one;
            end
            if (do_push && !do_pop) begin
                count <= count + c_cnt_one;
            end else if (!do_push && do_pop) begin
                count <= count - c_cnt_one;
            end
        end
    end

    // The scheduler reserves a whole burst of space before requesting,
    // so a beat arriving at a full FIFO means the memory broke protocol.
    push_into_full: assert property (@(posedge clk_pixel) disable iff (reset)
        !(push && !flush && full));

endmodule

// File: rtl/vga_fetch_scheduler.sv
// Frame-buffer read scheduler feeding the VGA timing generator.
// Issues burst reads one frame ahead of the beam, buffers {r,g,b} words in
// a FWFT FIFO and pops on fetch_next. A rising vblank edge restarts the
// frame at fb_base once no burst is in flight.
// Optional build macro VGA_FETCH_UNDERRUN_CNT_EN adds a per-frame
// saturating underrun counter output (underrun_cnt).
module vga_fetch_scheduler
    import vga_fetch_pkg::*;
#(
    parameter int c_resolution_x = 640,
    parameter int c_resolution_y = 480,
    parameter int c_burst        = 16,
    parameter int c_fifo_bits    = 9,
    parameter int c_addr_bits    = 24
) (
    input  logic                   clk_pixel,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [c_addr_bits-1:0] fb_base,
    input  logic                   vga_vblank,
    input  logic                   fetch_next,
    output logic [7:0]             r_o,
    output logic [7:0]             g_o,
    output logic [7:0]             b_o,
    output logic                   mem_req,
    output logic [c_addr_bits-1:0] mem_addr,
    input  logic                   mem_ack,
    input  logic                   mem_valid,
    input  logic [c_pix_bits-1:0]  mem_rdata,
    output logic                   underrun,
`ifdef VGA_FETCH_UNDERRUN_CNT_EN
    output logic [15:0]            underrun_cnt,
`endif
    output logic                   frame_busy
);

    localparam int c_bursts    = (c_resolution_x * c_resolution_y) / c_burst;
    localparam int c_rem_bits  = $clog2(c_bursts + 1);
    localparam int c_beat_bits = $clog2(c_burst + 1);

    localparam logic [c_rem_bits-1:0]  c_bursts_v  = c_rem_bits'(c_bursts);
    localparam logic [c_rem_bits-1:0]  c_rem_one   = c_rem_bits'(1);
    localparam logic [c_beat_bits-1:0] c_beat_one  = c_beat_bits'(1);
    localparam logic [c_beat_bits-1:0] c_last_beat = c_beat_bits'(c_burst - 1);
    localparam logic [c_fifo_bits:0]   c_burst_free = (c_fifo_bits + 1)'(c_burst);
    localparam logic [c_addr_bits-1:0] c_addr_step = c_addr_bits'(c_burst);

    fetch_state_t           state;
    fetch_state_t           state_next;
    logic [c_addr_bits-1:0] addr;
    logic [c_rem_bits-1:0]  remaining;
    logic [c_beat_bits-1:0] beat_cnt;
    logic                   vblank_q;
    logic                   resync_pend;
    logic                   vblank_rise;
    logic                   burst_idle;
    logic                   honour;
    logic                   ack_take;
    logic                   beat_push;
    logic                   last_beat;
    logic                   empty_pop;
    logic [c_pix_bits-1:0]  head;
    logic [c_fifo_bits:0]   fifo_count;
    logic [c_fifo_bits:0]   fifo_free;

    // A frame start may only take effect between bursts, and only while
    // fetching is enabled; until then it stays pending.
    assign vblank_rise = vga_vblank && !vblank_q;
    assign burst_idle  = (state != S_REQ) && (state != S_DATA);
    assign honour      = resync_pend && enable && burst_idle;
    assign ack_take    = (state == S_REQ) && mem_ack;
    assign beat_push   = (state == S_DATA) && mem_valid;
    assign last_beat   = beat_push && (beat_cnt == c_last_beat);
    assign empty_pop   = fetch_next && (fifo_count == '0);

    assign mem_req    = (state == S_REQ);
    assign mem_addr   = addr;
    assign frame_busy = (remaining != '0) || !burst_idle;

    assign r_o = pix_field(head, c_r_lsb);
    assign g_o = pix_field(head, c_g_lsb);
    assign b_o = pix_field(head, c_b_lsb);

    vga_fetch_fifo #(
        .c_fifo_bits (c_fifo_bits)
    ) u_fifo (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .push      (beat_push),
        .pop       (fetch_next),
        .flush     (honour),
        .wdata     (mem_rdata),
        .head      (head),
        .count     (fifo_count),
        .free      (fifo_free)
    );

    // FSM state register.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a pending frame start outranks issuing a new burst.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (honour) begin
                    state_next = S_FILL;
                end
            end
            S_FILL: begin
                if (!enable) begin
                    state_next = S_IDLE;
                end else if (honour) begin
                    state_next = S_FILL;
                end else if (remaining == '0) begin
                    state_next = S_DONE;
                end else if (fifo_free >= c_burst_free) begin
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_ack) begin
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (last_beat) begin
                    state_next = enable ? S_FILL : S_IDLE;
                end
            end
            S_DONE: begin
                if (!enable) begin
                    state_next = S_IDLE;
                end else if (honour) begin
                    state_next = S_FILL;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Address, burst countdown and beat counter; addresses wrap modulo 2^c_addr_bits.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            addr      <= '0;
            remaining <= '0;
            beat_cnt  <= '0;
        end else begin
            if (honour) begin
                addr      <= fb_base;
                remaining <= c_bursts_v;
            end else if (ack_take) begin
                addr      <= addr + c_addr_step;
                remaining <= remaining - c_rem_one;
                beat_cnt  <= '0;
            end
            if (beat_push) begin
                beat_cnt <= beat_cnt + c_beat_one;
            end
        end
    end

    // Vblank edge detect and the pending frame-start flag.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            vblank_q    <= 1'b0;
            resync_pend <= 1'b0;
        end else begin
            vblank_q    <= vga_vblank;
            resync_pend <= vblank_rise || (resync_pend && !honour);
        end
    end

    // Sticky underrun flag, cleared only when a new frame starts.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            underrun <= 1'b0;
        end else if (honour) begin
            underrun <= 1'b0;
        end else if (empty_pop) begin
            underrun <= 1'b1;
        end
    end

`ifdef VGA_FETCH_UNDERRUN_CNT_EN
    // Per-frame count of pops against an empty FIFO, saturating.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            underrun_cnt <= '0;
        end else if (honour) begin
            underrun_cnt <= '0;
        end else if (empty_pop && (underrun_cnt != 16'hFFFF)) begin
            underrun_cnt <= underrun_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_fetch_scheduler.sv
// Self-checking bench for vga_fetch_scheduler (X=8, Y=2, burst 4, FIFO 8).
// A randomised memory slave answers requests; a queue-based model tracks
// expected FIFO contents, frame progress and the sticky underrun flag.
module tb_vga_fetch_scheduler;

    localparam int X      = 8;
    localparam int Y      = 2;
    localparam int B      = 4;
    localparam int FBITS  = 3;
    localparam int ABITS  = 12;
    localparam int TOTAL  = (X * Y) / B;
    localparam int DEPTH  = 1 << FBITS;

    logic              clk_pixel = 1'b0;
    logic              reset;
    logic              enable;
    logic [ABITS-1:0]  fb_base;
    logic              vga_vblank;
    logic              fetch_next;
    logic [7:0]        r_o;
    logic [7:0]        g_o;
    logic [7:0]        b_o;
    logic              mem_req;
    logic [ABITS-1:0]  mem_addr;
    logic              mem_ack;
    logic              mem_valid;
    logic [23:0]       mem_rdata;
    logic              underrun;
    logic              frame_busy;
`ifdef VGA_FETCH_UNDERRUN_CNT_EN
    logic [15:0]       underrun_cnt;
`endif

    always #5 clk_pixel = ~clk_pixel;

    vga_fetch_scheduler #(
        .c_resolution_x (X),
        .c_resolution_y (Y),
        .c_burst        (B),
        .c_fifo_bits    (FBITS),
        .c_addr_bits    (ABITS)
    ) dut (
        .clk_pixel  (clk_pixel),
        .reset      (reset),
        .enable     (enable),
        .fb_base    (fb_base),
        .vga_vblank (vga_vblank),
        .fetch_next (fetch_next),
        .r_o        (r_o),
        .g_o        (g_o),
        .b_o        (b_o),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_valid  (mem_valid),
        .mem_rdata  (mem_rdata),
        .underrun   (underrun),
`ifdef VGA_FETCH_UNDERRUN_CNT_EN
        .underrun_cnt (underrun_cnt),
`endif
        .frame_busy (frame_busy)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [23:0]      pix_q[$];
    logic [ABITS-1:0] req_log[$];
    logic             m_underrun;
    int               m_ucnt;
    int               acks_in_frame;
    int               beats_pending;
    logic [ABITS-1:0] exp_addr;
    bit               m_pend;
    logic             prev_vblank;
    bit               req_seen;
    int               slave_wait;
    bit               stray_valid_en;
    logic [ABITS-1:0] wrap_addr;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        pix_q.delete();
        m_underrun    = 1'b0;
        m_ucnt        = 0;
        acks_in_frame = TOTAL;
        beats_pending = 0;
        exp_addr      = '0;
        m_pend        = 1'b0;
        prev_vblank   = 1'b0;
        slave_wait    = -1;
    endtask

    // One pixel clock: drive inputs at the negedge, advance the model at the
    // posedge, then compare outputs at the following negedge.
    task automatic applyStimulus(input bit pop);
        bit honour_now;
        req_seen   = mem_req;
        fetch_next = pop;
        mem_ack    = 1'b0;
        mem_valid  = 1'b0;
        mem_rdata  = 24'($urandom);
        if (mem_req) begin
            checkOutput("req_addr", 32'(mem_addr), 32'(exp_addr));
            checkOutput("req_room", 32'(pix_q.size() <= DEPTH - B), 32'(1));
            checkOutput("req_in_frame", 32'(acks_in_frame < TOTAL), 32'(1));
            if (slave_wait < 0) slave_wait = $urandom_range(0, 2);
            if (slave_wait == 0) begin
                mem_ack    = 1'b1;
                slave_wait = -1;
                req_log.push_back(mem_addr);
            end else begin
                slave_wait--;
            end
        end
        if (beats_pending > 0) mem_valid = ($urandom_range(0, 3) != 0);
        else if (stray_valid_en) mem_valid = 1'($urandom_range(0, 1));

        @(posedge clk_pixel);
        honour_now = m_pend && enable && !req_seen && (beats_pending == 0);
        if (fetch_next) begin
            if (pix_q.size() > 0) void'(pix_q.pop_front());
            else begin
                m_underrun = 1'b1;
                if (m_ucnt < 65535) m_ucnt++;
            end
        end
        if (mem_valid && beats_pending > 0) begin
            pix_q.push_back(mem_rdata);
            beats_pending--;
        end
        if (mem_ack && req_seen) begin
            exp_addr      = exp_addr + ABITS'(B);
            acks_in_frame++;
            beats_pending = B;
        end
        if (honour_now) begin
            pix_q.delete();
            m_underrun    = 1'b0;
            m_ucnt        = 0;
            exp_addr      = fb_base;
            acks_in_frame = 0;
        end
        m_pend      = (vga_vblank && !prev_vblank) || (m_pend && !honour_now);
        prev_vblank = vga_vblank;

        @(negedge clk_pixel);
        checkOutput("rgb_head", 32'({r_o, g_o, b_o}), 32'((pix_q.size() > 0) ? pix_q[0] : 24'h0));
        checkOutput("underrun", 32'(underrun), 32'(m_underrun));
        checkOutput("frame_busy", 32'(frame_busy), 32'((acks_in_frame < TOTAL) || (beats_pending > 0)));
`ifdef VGA_FETCH_UNDERRUN_CNT_EN
        checkOutput("underrun_cnt", 32'(underrun_cnt), 32'(m_ucnt));
`endif
    endtask

    initial begin
        reset          = 1'b1;
        enable         = 1'b0;
        fb_base        = '0;
        vga_vblank     = 1'b0;
        fetch_next     = 1'b0;
        mem_ack        = 1'b0;
        mem_valid      = 1'b0;
        mem_rdata      = '0;
        stray_valid_en = 1'b0;
        modelReset();
        repeat (3) @(negedge clk_pixel);
        checkOutput("reset_rgb", 32'({r_o, g_o, b_o}), 32'(0));
        checkOutput("reset_req", 32'(mem_req), 32'(0));
        checkOutput("reset_addr", 32'(mem_addr), 32'(0));
        checkOutput("reset_underrun", 32'(underrun), 32'(0));
        checkOutput("reset_busy", 32'(frame_busy), 32'(0));
        reset = 1'b0;

        // Startup: two bursts fill the FIFO, then no third request without pops
        enable  = 1'b1;
        fb_base = 12'h100;
        vga_vblank = 1'b1;
        applyStimulus(1'b0);
        vga_vblank = 1'b0;
        for (int n = 0; n < 80 && !(acks_in_frame == 2 && beats_pending == 0); n++) applyStimulus(1'b0);
        checkOutput("two_bursts_done", 32'(acks_in_frame == 2 && beats_pending == 0), 32'(1));
        checkOutput("first_req_addr", 32'((req_log.size() > 0) ? req_log[0] : 'x), 32'(12'h100));
        repeat (8) applyStimulus(1'b0);
        checkOutput("no_third_req", 32'(mem_req), 32'(0));
        checkOutput("busy_mid_frame", 32'(frame_busy), 32'(1));

        // Pop order: fetch_next every other cycle until the frame is fetched
        for (int n = 0; n < 200 && !(acks_in_frame == TOTAL && beats_pending == 0); n++) applyStimulus(n[0]);
        checkOutput("frame_fetched", 32'(acks_in_frame == TOTAL && beats_pending == 0), 32'(1));
        checkOutput("busy_drop", 32'(frame_busy), 32'(0));

        // Underrun: new frame, three pops before any beat arrives
        vga_vblank = 1'b1;
        applyStimulus(1'b0);
        vga_vblank = 1'b0;
        applyStimulus(1'b0);
        checkOutput("underrun_cleared", 32'(underrun), 32'(0));
        applyStimulus(1'b1);
        checkOutput("underrun_rgb_zero", 32'({r_o, g_o, b_o}), 32'(0));
        checkOutput("underrun_set", 32'(underrun), 32'(1));
        applyStimulus(1'b1);
        applyStimulus(1'b1);
`ifdef VGA_FETCH_UNDERRUN_CNT_EN
        checkOutput("underrun_cnt_three", 32'(underrun_cnt), 32'(3));
`endif

        // Late vblank: edge after beat 2 of a burst is deferred
        for (int n = 0; n < 60 && beats_pending != 2; n++) applyStimulus(1'b0);
        checkOutput("reached_beat2", 32'(beats_pending), 32'(2));
        checkOutput("underrun_sticky", 32'(underrun), 32'(1));
        fb_base    = 12'h200;
        vga_vblank = 1'b1;
        applyStimulus(1'b0);
        vga_vblank = 1'b0;
        for (int n = 0; n < 40 && !mem_req; n++) applyStimulus(1'b0);
        checkOutput("late_req_addr", 32'(mem_addr), 32'(12'h200));
        checkOutput("late_underrun_clr", 32'(underrun), 32'(0));
        checkOutput("late_flushed_rgb", 32'({r_o, g_o, b_o}), 32'(0));

        // Random traffic: random pops, periodic vblank, occasional disable
        stray_valid_en = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if (n % 60 == 0) fb_base = ABITS'($urandom);
            vga_vblank = ((n % 60) == 10) || ((n % 60) == 11);
            enable     = ($urandom_range(0, 15) != 0);
            applyStimulus(1'($urandom_range(0, 1)));
        end
        vga_vblank = 1'b0;
        enable     = 1'b1;

        // Reset mid-burst
        fb_base    = 12'h300;
        vga_vblank = 1'b1;
        applyStimulus(1'b0);
        vga_vblank = 1'b0;
        for (int n = 0; n < 60 && !mem_req; n++) applyStimulus(1'b0);
        checkOutput("rst_wait_req", 32'(mem_req), 32'(1));
        #2;
        reset      = 1'b1;
        mem_ack    = 1'b0;
        mem_valid  = 1'b0;
        fetch_next = 1'b0;
        #1;
        checkOutput("async_req_drop", 32'(mem_req), 32'(0));
        checkOutput("async_rgb_zero", 32'({r_o, g_o, b_o}), 32'(0));
        checkOutput("async_busy_zero", 32'(frame_busy), 32'(0));
        checkOutput("async_addr_zero", 32'(mem_addr), 32'(0));
        @(negedge clk_pixel);
        reset = 1'b0;
        modelReset();
        for (int n = 0; n < 10; n++) begin
            applyStimulus(1'($urandom_range(0, 1)));
            checkOutput("post_reset_idle", 32'(mem_req), 32'(0));
        end
        stray_valid_en = 1'b0;

        // Address wrap across a frame starting at 0xFF8
        fb_base = 12'hFF8;
        req_log.delete();
        vga_vblank = 1'b1;
        applyStimulus(1'b0);
        vga_vblank = 1'b0;
        for (int n = 0; n < 300 && !(acks_in_frame == TOTAL && beats_pending == 0); n++)
            applyStimulus(1'($urandom_range(0, 1)));
        checkOutput("wrap_frame_done", 32'(acks_in_frame == TOTAL && beats_pending == 0), 32'(1));
        wrap_addr = (req_log.size() >= 3) ? req_log[2] : 'x;
        checkOutput("wrap_addr", 32'(wrap_addr), 32'(12'h000));

        // Disable while a request is pending: burst completes, FSM parks
        fb_base    = 12'hFFC;
        vga_vblank = 1'b1;
        applyStimulus(1'b0);
        vga_vblank = 1'b0;
        for (int n = 0; n < 40 && !mem_req; n++) applyStimulus(1'b0);
        checkOutput("dis_req_addr", 32'(mem_addr), 32'(12'hFFC));
        enable = 1'b0;
        for (int n = 0; n < 40 && !(acks_in_frame == 1 && beats_pending == 0); n++) applyStimulus(1'b0);
        checkOutput("dis_burst_done", 32'(acks_in_frame == 1 && beats_pending == 0), 32'(1));
        repeat (6) applyStimulus(1'b0);
        checkOutput("dis_parked_req", 32'(mem_req), 32'(0));
        checkOutput("dis_busy", 32'(frame_busy), 32'(1));
        checkOutput("dis_fifo_words", 32'(pix_q.size()), 32'(B));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
